dummy_copr_iter_unit: RTL and testbench

// - Iterative execution unit of the dummy coprocessor: the responder to the dummy-coprocessor reservation station.
// - Accepts one instruction at a time, holds it for a programmable latency and returns the result and ROB index on the CDB.
// - Present only when LEN5_DUMMY_COPR_EN = 1. Pipelined dummy instructions are out of scope for this block.

---
 rtl/dummy_copr_iter_unit.sv | 99 +++++++++
 tb/tb_dummy_copr_iter_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_copr_iter_unit.sv
// Iterative execution unit of the dummy coprocessor.
// Holds one instruction for a programmable latency, then returns its result on the CDB.
module dummy_copr_iter_unit #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned ROB_IDX_LEN = 5,
   parameter int unsigned MAX_LATENCY = 128,
   parameter int unsigned LAT_W       = $clog2(MAX_LATENCY + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   issue_valid_i,
   output logic                   issue_ready_o,
   input  logic [1:0]             issue_op_i,
   input  logic [LAT_W-1:0]       issue_latency_i,
   input  logic [XLEN-1:0]        issue_rs1_i,
   input  logic [XLEN-1:0]        issue_rs2_i,
   input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,
   output logic                   cdb_valid_o,
   input  logic                   cdb_ready_i,
   output logic [ROB_IDX_LEN-1:0] cdb_rob_idx_o,
   output logic [XLEN-1:0]        cdb_res_o,
   output logic                   cdb_except_raised_o,
   output logic                   busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_LATENCY);

   logic [1:0]             r_state;
   logic [LAT_W-1:0]       r_cnt;
   logic [XLEN-1:0]        r_res;
   logic [ROB_IDX_LEN-1:0] r_rob;
   logic                   r_exc;

   logic                   w_accept;
   logic [LAT_W-1:0]       w_lat;
   logic [XLEN-1:0]        w_res;
   logic                   w_exc;

   assign issue_ready_o = (r_state == IDLE) & ~flush_i;
   assign w_accept      = issue_valid_i & issue_ready_o;
   assign w_lat         = (issue_latency_i > MAX_LAT) ? MAX_LAT : issue_latency_i;

   always_comb begin
      w_res = '0;
      w_exc = 1'b0;
      case (issue_op_i)
         2'b00:   w_res = issue_rs1_i + issue_rs2_i;
         2'b01:   w_res = issue_rs1_i ^ issue_rs2_i;
         2'b10:   w_res = issue_rs1_i;
         default: w_exc = 1'b1;
      endcase
   end

   // Flush outranks both accept and the CDB handshake; reset outranks flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_res   <= '0;
         r_rob   <= '0;
         r_exc   <= 1'b0;
      end else if (flush_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_res <= w_res;
                  r_rob <= issue_rob_idx_i;
                  r_exc <= w_exc;
                  r_cnt <= w_lat;
                  r_state <= (w_lat == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt - LAT_W'(1);
               if (r_cnt <= LAT_W'(1)) r_state <= DONE;
            end
            DONE: begin
               if (cdb_ready_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cdb_valid_o         = (r_state == DONE) & ~flush_i;
   assign cdb_rob_idx_o       = cdb_valid_o ? r_rob : '0;
   assign cdb_res_o           = cdb_valid_o ? r_res : '0;
   assign cdb_except_raised_o = cdb_valid_o & r_exc;
   assign busy_o              = (r_state != IDLE);

endmodule

// File: tb/tb_dummy_copr_iter_unit.sv
// Scoreboard bench for dummy_copr_iter_unit: expected CDB results queued at issue, checked on output.
module tb_dummy_copr_iter_unit;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned RW    = 5;
   localparam int unsigned LAT_W = 8;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [RW-1:0]   rob;
      logic            exc;
      int              acc;
      int              lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             flush_i = 1'b0;
   logic             issue_valid_i = 1'b0;
   logic             issue_ready_o;
   logic [1:0]       issue_op_i = '0;
   logic [LAT_W-1:0] issue_latency_i = '0;
   logic [XLEN-1:0]  issue_rs1_i = '0;
   logic [XLEN-1:0]  issue_rs2_i = '0;
   logic [RW-1:0]    issue_rob_idx_i = '0;
   logic             cdb_valid_o;
   logic             cdb_ready_i = 1'b0;
   logic [RW-1:0]    cdb_rob_idx_o;
   logic [XLEN-1:0]  cdb_res_o;
   logic             cdb_except_raised_o;
   logic             busy_o;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   prev_v = 1'b0;
   exp_t sb[$];

   dummy_copr_iter_unit #(.XLEN(XLEN), .ROB_IDX_LEN(RW), .MAX_LATENCY(128), .LAT_W(LAT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_op_i(issue_op_i),
      .issue_latency_i(issue_latency_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_rob_idx_i(issue_rob_idx_i), .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i),
      .cdb_rob_idx_o(cdb_rob_idx_o), .cdb_res_o(cdb_res_o),
      .cdb_except_raised_o(cdb_except_raised_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: every cycle with valid high must match the queue head; valid low means zero outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cdb_valid_o) begin
            if (sb.size() == 0) check("spurious_valid", 64'(cdb_valid_o), 64'd0);
            else begin
               if (!prev_v) check("latency", 64'(cyc - sb[0].acc), 64'(1 + sb[0].lat));
               check("res", cdb_res_o, sb[0].res);
               check("rob", 64'(cdb_rob_idx_o), 64'(sb[0].rob));
               check("exc", 64'(cdb_except_raised_o), 64'(sb[0].exc));
               if (cdb_ready_i) void'(sb.pop_front());
            end
         end else begin
            check("idle_res_zero", cdb_res_o, 64'd0);
            check("idle_rob_exc_zero", 64'({cdb_except_raised_o, cdb_rob_idx_o}), 64'd0);
         end
         prev_v = cdb_valid_o;
      end
   end

   function automatic logic [XLEN-1:0] model_res(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a ^ b;
         2'b10:   return a;
         default: return '0;
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input int lat, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RW-1:0] rob, output int acc);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      while (!issue_ready_o && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (!issue_ready_o) check("issue_ready_timeout", 64'd0, 64'd1);
      issue_op_i      = op;
      issue_latency_i = LAT_W'(lat);
      issue_rs1_i     = a;
      issue_rs2_i     = b;
      issue_rob_idx_i = rob;
      issue_valid_i   = 1'b1;
      acc   = cyc;
      e.res = model_res(op, a, b);
      e.rob = rob;
      e.exc = (op == 2'b11);
      e.acc = cyc;
      e.lat = (lat > 128) ? 128 : lat;
      sb.push_back(e);
      @(posedge clk);
      #1 issue_valid_i = 1'b0;
   endtask

   task automatic wait_empty(input int limit);
      int k = 0;
      while (sb.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int acc;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(issue_ready_o), 64'd1);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_valid", 64'(cdb_valid_o), 64'd0);
      mon_en = 1'b1;

      // ADD, latency 3, immediate CDB acceptance
      cdb_ready_i = 1'b1;
      issue(2'b00, 3, 64'd5, 64'd7, 5'd4, acc);
      while (cyc < acc + 4) @(negedge clk);
      check("t1_ready_c4", 64'(issue_ready_o), 64'd0);
      @(negedge clk);
      check("t1_ready_c5", 64'(issue_ready_o), 64'd1);
      wait_empty(20);

      // XOR, latency 0, CDB stalled 3 cycles with another instruction pending
      cdb_ready_i = 1'b0;
      issue(2'b01, 0, 64'hFF, 64'h0F, 5'd9, acc);
      issue_valid_i = 1'b1;
      issue_op_i    = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_hold_ready", 64'(issue_ready_o), 64'd0);
         check("t2_hold_valid", 64'(cdb_valid_o), 64'd1);
      end
      @(posedge clk);
      #1 issue_valid_i = 1'b0;
      cdb_ready_i = 1'b1;
      wait_empty(20);

      // Wraparound ADD and illegal op
      issue(2'b00, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, acc);
      wait_empty(20);
      issue(2'b11, 1, 64'hDEAD_BEEF, 64'h1234, 5'd2, acc);
      wait_empty(20);

      // Latency above the maximum is clamped
      issue(2'b10, 255, 64'h1234, 64'h5678, 5'd7, acc);
      wait_empty(300);

      // Flush while busy: instruction is lost
      issue(2'b00, 10, 64'd100, 64'd1, 5'd11, acc);
      while (cyc != acc + 4) begin
         @(posedge clk);
         #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      check("t5_flush_ready", 64'(issue_ready_o), 64'd0);
      check("t5_flush_valid", 64'(cdb_valid_o), 64'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      sb.delete();
      @(negedge clk);
      check("t5_busy_after", 64'(busy_o), 64'd0);
      @(negedge clk);
      check("t5_ready_c6", 64'(issue_ready_o), 64'd1);
      repeat (15) @(negedge clk);
      issue(2'b01, 4, 64'hA5A5, 64'h5A5A, 5'd12, acc);
      wait_empty(20);

      // Flush together with cdb_ready in DONE: no handshake
      cdb_ready_i = 1'b0;
      issue(2'b00, 1, 64'd3, 64'd4, 5'd13, acc);
      begin
         int k = 0;
         while (!cdb_valid_o && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      check("t6_valid_seen", 64'(cdb_valid_o), 64'd1);
      @(posedge clk);
      #1 flush_i = 1'b1;
      cdb_ready_i = 1'b1;
      @(negedge clk);
      check("t6_flush_valid", 64'(cdb_valid_o), 64'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      sb.delete();
      @(negedge clk);
      check("t6_idle_busy", 64'(busy_o), 64'd0);
      check("t6_idle_ready", 64'(issue_ready_o), 64'd1);

      // Reset pulse mid-busy
      issue(2'b00, 20, 64'd8, 64'd9, 5'd20, acc);
      repeat (5) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      sb.delete();
      @(negedge clk);
      check("t7_rst_ready", 64'(issue_ready_o), 64'd1);
      check("t7_rst_busy", 64'(busy_o), 64'd0);
      check("t7_rst_valid", 64'(cdb_valid_o), 64'd0);
      repeat (30) @(negedge clk);
      issue(2'b10, 2, 64'hCAFE, 64'd0, 5'd31, acc);
      wait_empty(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
